// File: rtl/cpu_run_ctrl_if.sv
// Program-load stream and instruction-memory write port of the run controller.
// The slave side is the controller; the master side is the loader/memory.
interface cpu_run_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              ld_valid;
  logic [31:0]       ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [31:0]       im_wdata;

  modport master (
    output ld_valid,
    output ld_data,
    output ld_last,
    input  ld_ready,
    input  im_we,
    input  im_waddr,
    input  im_wdata
  );

  modport slave (
    input  ld_valid,
    input  ld_data,
    input  ld_last,
    output ld_ready,
    output im_we,
    output im_waddr,
    output im_wdata
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Loads a program into instruction memory, resets the CPU, runs it and
// reports pass/fail from the a0 debug value, a noop flag or a cycle budget.
module cpu_run_ctrl #(
  parameter int         ROM_SIZE   = 1024,
  parameter int         ADDR_W     = $clog2(ROM_SIZE),
  parameter int         RST_CYCLES = 2,
  parameter logic [4:0] IO_REG     = 5'd10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [31:0]        expect_data,
  input  logic [15:0]        max_cycles,
  cpu_run_ctrl_if.slave      ld,
  output logic               cpu_rst,
  input  logic               cpu_noop,
  output logic [4:0]         cpu_regAddr,
  input  logic [31:0]        cpu_regData,
  output logic               done,
  output logic               pass,
  output logic [15:0]        cycles
);

  localparam int PH_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CRST,
    S_RUN,
    S_DONE
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [PH_W-1:0]   phase_q;
  logic [15:0]       cycles_q;
  logic              done_q;
  logic              pass_q;

  logic        hs;
  logic        addr_end;
  logic        hit;
  logic        spent;
  logic [15:0] cycles_d;

  assign hs       = (state_q == S_LOAD) & ld.ld_valid;
  assign addr_end = addr_q == ADDR_W'(ROM_SIZE - 1);
  assign hit      = cpu_noop | (cpu_regData == expect_data);
  assign cycles_d = cycles_q + 16'd1;
  // 17-bit compare so a budget of 0 or 16'hffff never wraps
  assign spent    = ({1'b0, cycles_q} + 17'd1) >= {1'b0, max_cycles};

  assign ld.ld_ready  = state_q == S_LOAD;
  assign ld.im_we     = hs;
  assign ld.im_waddr  = addr_q;
  assign ld.im_wdata  = ld.ld_data;

  assign cpu_rst     = state_q != S_RUN;
  assign cpu_regAddr = IO_REG;
  assign done        = done_q;
  assign pass        = pass_q;
  assign cycles      = cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      phase_q  <= '0;
      cycles_q <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_LOAD;
            addr_q  <= '0;
          end
        end
        S_LOAD: begin
          if (hs) begin
            addr_q <= addr_q + 1'b1;
            if (ld.ld_last || addr_end) begin
              state_q <= S_CRST;
              phase_q <= '0;
            end
          end
        end
        S_CRST: begin
          if (phase_q == PH_W'(RST_CYCLES - 1)) begin
            state_q  <= S_RUN;
            cycles_q <= '0;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        S_RUN: begin
          cycles_q <= cycles_d;
          if (hit || spent) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            pass_q  <= hit;
          end
        end
        S_DONE: begin
          if (start) begin
            state_q <= S_LOAD;
            addr_q  <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a cycle model of the controller's rules
// plus literal expectations for each scenario.
module tb_cpu_run_ctrl;

  localparam int ROM  = 1024;
  localparam int RSTC = 2;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RST  = 2;
  localparam int M_RUN  = 3;
  localparam int M_DONE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] expect_data;
  logic [15:0] max_cycles;
  logic        cpu_rst;
  logic        cpu_noop;
  logic [4:0]  cpu_regAddr;
  logic [31:0] cpu_regData;
  logic        done;
  logic        pass;
  logic [15:0] cycles;

  cpu_run_ctrl_if #(.ADDR_W(10)) bus ();

  cpu_run_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .expect_data (expect_data),
    .max_cycles  (max_cycles),
    .ld          (bus.slave),
    .cpu_rst     (cpu_rst),
    .cpu_noop    (cpu_noop),
    .cpu_regAddr (cpu_regAddr),
    .cpu_regData (cpu_regData),
    .done        (done),
    .pass        (pass),
    .cycles      (cycles)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // CPU stand-in: counts cycles out of reset, raises noop or a0 on request
  int noop_at = 0;
  int match_at = 0;
  int cpu_cnt = 0;

  always @(posedge clk) begin
    if (cpu_rst !== 1'b0) cpu_cnt <= 0;
    else cpu_cnt <= cpu_cnt + 1;
  end

  always_comb begin
    cpu_noop = 1'b0;
    cpu_regData = 32'h5a5a_0000 | cpu_cnt[15:0];
    if (cpu_rst === 1'b0) begin
      if (noop_at != 0 && cpu_cnt + 1 == noop_at) cpu_noop = 1'b1;
      if (match_at != 0 && cpu_cnt + 1 == match_at) cpu_regData = expect_data;
    end
  end

  // Reference model: tracks phase, words accepted, run length and verdict
  int m_mode = M_IDLE;
  int m_words = 0;
  int m_rst_left = 0;
  int m_run = 0;
  bit m_done = 0;
  bit m_pass = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = M_IDLE;
      m_words = 0;
      m_run = 0;
      m_done = 0;
      m_pass = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (start) begin
          m_mode = M_LOAD;
          m_words = 0;
        end
        M_LOAD: if (bus.ld_valid) begin
          m_words++;
          if (bus.ld_last || m_words == ROM) begin
            m_mode = M_RST;
            m_rst_left = RSTC;
          end
        end
        M_RST: begin
          m_rst_left--;
          if (m_rst_left == 0) begin
            m_mode = M_RUN;
            m_run = 0;
          end
        end
        M_RUN: begin
          m_run++;
          if (cpu_noop || cpu_regData == expect_data) begin
            m_mode = M_DONE;
            m_done = 1;
            m_pass = 1;
          end else if (m_run >= int'(max_cycles)) begin
            m_mode = M_DONE;
            m_done = 1;
            m_pass = 0;
          end
        end
        M_DONE: if (start) begin
          m_mode = M_LOAD;
          m_words = 0;
          m_done = 0;
          m_pass = 0;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("regAddr", cpu_regAddr, 32'd10);
      chk("cpu_rst", cpu_rst, m_mode != M_RUN);
      chk("ld_ready", bus.ld_ready, m_mode == M_LOAD);
      chk("im_we", bus.im_we, m_mode == M_LOAD && bus.ld_valid);
      if (m_mode == M_LOAD && bus.ld_valid) begin
        chk("im_waddr", bus.im_waddr, m_words);
        chk("im_wdata", bus.im_wdata, bus.ld_data);
      end
      chk("done", done, m_done);
      chk("pass", pass, m_pass);
      chk("cycles", cycles, m_run);
    end
  end

  // Write scoreboard
  int wr_cnt = 0;
  int first_addr = -1;
  logic [31:0] wr_mem [int];

  always @(negedge clk) begin
    if (bus.im_we === 1'b1) begin
      if (wr_cnt == 0) first_addr = int'(bus.im_waddr);
      wr_cnt++;
      wr_mem[int'(bus.im_waddr)] = bus.im_wdata;
    end
  end

  task automatic clear_sb();
    wr_cnt = 0;
    first_addr = -1;
    wr_mem.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_data = d;
    bus.ld_last = last;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    chk("done_reached", done, 1'b1);
  endtask

  task automatic verdict(input string nm, input logic p, input int c);
    chk({nm, "_done"}, done, 1'b1);
    chk({nm, "_pass"}, pass, p);
    chk({nm, "_cycles"}, cycles, c);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1;
    start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data = '0;
    bus.ld_last = 1'b0;
    expect_data = 32'hdead_beef;
    max_cycles = 16'd1000;
    tick();
    chk_en = 1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cpu_rst", cpu_rst, 1'b1);
    chk("rst_ld_ready", bus.ld_ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cycles", cycles, 16'd0);
    tick();
    tick();
    chk("idle_hold_pass", pass, 1'b0);

    // three words with a stall, noop on run cycle 5
    clear_sb();
    noop_at = 5;
    do_start();
    send_word(32'h1000_0001, 1'b0);
    tick();
    send_word(32'h1000_0002, 1'b0);
    send_word(32'h1000_0003, 1'b1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cpu_rst === 1'b1) cnt++;
      else break;
    end
    chk("crst_len", cnt, 2);
    wait_done(50);
    verdict("noop", 1'b1, 5);
    chk("ld3_count", wr_cnt, 3);
    chk("ld3_first", first_addr, 0);
    chk("ld3_w0", wr_mem[0], 32'h1000_0001);
    chk("ld3_w2", wr_mem[2], 32'h1000_0003);
    tick();
    tick();
    chk("done_frozen", cycles, 16'd5);
    noop_at = 0;

    // a0 match on cycle 40
    expect_data = 32'h0021_3d05;
    match_at = 40;
    do_start();
    send_word(32'h0000_0013, 1'b1);
    wait_done(100);
    verdict("a0match", 1'b1, 40);

    // budget of 10 with an ignored start mid-run
    match_at = 0;
    max_cycles = 16'd10;
    do_start();
    send_word(32'h0000_0013, 1'b1);
    repeat (4) tick();
    do_start();
    wait_done(50);
    verdict("budget10", 1'b0, 10);

    // zero budget
    max_cycles = 16'd0;
    do_start();
    send_word(32'h0000_0013, 1'b1);
    wait_done(20);
    verdict("budget0", 1'b0, 1);

    // match coincident with budget expiry
    max_cycles = 16'd7;
    match_at = 7;
    do_start();
    send_word(32'h0000_0013, 1'b1);
    wait_done(30);
    verdict("tie", 1'b1, 7);

    // overflow guard: 1025 words, no last
    match_at = 0;
    max_cycles = 16'd3;
    clear_sb();
    do_start();
    bus.ld_valid = 1'b1;
    bus.ld_last = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      bus.ld_data = 32'(i) ^ 32'hc000_0000;
      tick();
    end
    bus.ld_data = 32'hffff_ffff;
    chk("ovf_ready", bus.ld_ready, 1'b0);
    chk("ovf_we", bus.im_we, 1'b0);
    tick();
    bus.ld_valid = 1'b0;
    chk("ovf_count", wr_cnt, 1024);
    chk("ovf_first", first_addr, 0);
    chk("ovf_last", wr_mem[1023], 32'hc000_03ff);
    wait_done(20);
    verdict("ovf_run", 1'b0, 3);

    // reset mid-load, then reload from address 0
    do_start();
    send_word(32'h2000_0001, 1'b0);
    send_word(32'h2000_0002, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstld_cpu_rst", cpu_rst, 1'b1);
    chk("rstld_ready", bus.ld_ready, 1'b0);
    chk("rstld_done", done, 1'b0);
    chk("rstld_cycles", cycles, 16'd0);
    clear_sb();
    max_cycles = 16'd1000;
    do_start();
    send_word(32'h3000_0001, 1'b1);
    chk("reload_first", first_addr, 0);
    chk("reload_count", wr_cnt, 1);

    // reset mid-run
    repeat (6) tick();
    chk("midrun_cycles", cycles, 16'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstrun_cpu_rst", cpu_rst, 1'b1);
    chk("rstrun_cycles", cycles, 16'd0);
    chk("rstrun_pass", pass, 1'b0);
    clear_sb();
    match_at = 3;
    do_start();
    send_word(32'h4000_0001, 1'b1);
    chk("rerun_first", first_addr, 0);
    wait_done(20);
    verdict("rerun", 1'b1, 3);

    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameter ROM_SIZE, default 1024, instruction memory depth in 32-bit words.
REQ-002 Parameter ADDR_W, default $clog2(ROM_SIZE), instruction memory word-address width.
REQ-003 Parameter RST_CYCLES, default 2, number of cycles the CPU reset is held after load.
REQ-004 Parameter IO_REG, default 5'd10 (a0), register observed through the CPU debug port.
REQ-005 clk  input  1  single clock; all state changes on posedge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to load and run a program.
REQ-008 expect_data  input  32  a0 value that signals success; sampled every RUN cycle.
REQ-009 max_cycles  input  16  RUN-cycle budget; sampled every RUN cycle.
REQ-010 ld_valid / ld_data[31:0] / ld_last  input  1/32/1  program word stream; ld_last marks the final word.
REQ-011 ld_ready  output  1  controller accepts a stream word this cycle.
REQ-012 im_we / im_waddr[ADDR_W-1:0] / im_wdata[31:0]  output  1/ADDR_W/32  instruction memory write port.
REQ-013 cpu_rst  output  1  reset driven to the CPU.
REQ-014 cpu_noop  input  1  CPU noop indication.
REQ-015 cpu_regAddr / cpu_regData  output 5 / input 32  CPU debug register port.
REQ-016 done / pass  output  1/1  run finished / run succeeded.
REQ-017 cycles  output  16  RUN cycles consumed by the current or last run.

Function
REQ-018 States: IDLE, LOAD, CPU_RST, RUN, DONE.
REQ-019 cpu_regAddr SHALL be the constant IO_REG in all states.
REQ-020 cpu_rst SHALL be 1 in every state except RUN.
REQ-021 IDLE: start=1 -> LOAD next cycle, with the write address counter cleared to 0.
REQ-022 LOAD: ld_ready=1; im_we = ld_valid & ld_ready, im_waddr = address counter, im_wdata = ld_data, all combinational; ld_ready, im_we = 0 in every other state.
REQ-023 Each LOAD handshake increments the address counter by 1.
REQ-024 Handshake with ld_last=1, or handshake at address ROM_SIZE-1 (overflow guard, ld_last ignored), -> CPU_RST; the next word is never written.
REQ-025 A LOAD with ld_valid=0 SHALL wait indefinitely with no write.
REQ-026 CPU_RST: hold exactly RST_CYCLES cycles (phase counter), then RUN; cycles cleared to 0 on entry to RUN.
REQ-027 RUN: every cycle, cycles increments by 1 and the state evaluates, in priority order: cpu_noop=1 or cpu_regData==expect_data -> DONE with pass=1; else {1'b0,cycles}+1 >= {1'b0,max_cycles} (17-bit compare) -> DONE with pass=0.
REQ-028 A pass condition coincident with budget exhaustion SHALL report pass=1.
REQ-029 max_cycles=0 SHALL fail after exactly 1 RUN cycle unless a pass condition is present in that cycle.
REQ-030 done and pass are registered: asserted from the first DONE cycle, held until leaving DONE; pass=0 outside DONE.
REQ-031 DONE: cycles frozen; start=1 -> LOAD (address cleared, done/pass cleared next cycle).
REQ-032 start in LOAD, CPU_RST or RUN SHALL be ignored.

Reset
REQ-033 rst=1 at any posedge, including mid-LOAD or mid-RUN, SHALL force IDLE next cycle: cpu_rst=1, ld_ready=0, im_we=0, done=0, pass=0, cycles=0, address counter=0.
REQ-034 Outputs SHALL hold their reset values from the first posedge with rst=1 until start is seen after rst deasserts.

Verification
REQ-035 Load 3 words (last on word 3), cpu_noop=1 on RUN cycle 5 -> writes to addr 0,1,2; cpu_rst high exactly RST_CYCLES=2 cycles; done=1, pass=1, cycles=5.
REQ-036 expect_data=32'h00213d05, cpu_regData reaches it on RUN cycle 40, max_cycles=1000 -> pass=1, cycles=40.
REQ-037 No pass condition, max_cycles=10 -> done=1, pass=0, cycles=10; max_cycles=0 -> pass=0, cycles=1.
REQ-038 regData match on the same cycle the budget expires (max_cycles=7, match on cycle 7) -> pass=1, cycles=7.
REQ-039 Stream 1025 words without ld_last, ROM_SIZE=1024 -> 1024 writes (addr 0..1023), word 1025 not accepted, then CPU_RST.
REQ-040 rst asserted mid-LOAD and mid-RUN -> IDLE next cycle with all REQ-033 values; a subsequent start reloads from address 0.
